// File: rtl/reg_io_arbiter.sv
// Arbitrates three requesters onto the single KSZ8851 register IO engine and
// sequences one command at a time, with a watchdog abort for a hung engine.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an eligible request while the engine sits in ST_WAIT
// ISSUE | NewCommand held high until the engine reaches ST_ADDR0
// BUSY  | engine running; waiting for ST_READ2 / ST_WRITE2
// DONE  | one-cycle ack (and err on abort) to the owner
module reg_io_arbiter #(
    parameter int          TIMEOUT   = 1023,
    parameter logic [3:0]  ST_WAIT   = 4'b1001,
    parameter logic [3:0]  ST_ADDR0  = 4'b0000,
    parameter logic [3:0]  ST_READ2  = 4'b0101,
    parameter logic [3:0]  ST_WRITE2 = 4'b1000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        init_busy,
    input  logic [2:0]  req,
    input  logic [2:0]  req_wr,
    input  logic [2:0]  req_len,
    input  logic [23:0] req_offset,
    input  logic [47:0] req_wdata,
    output logic [7:0]  offset,
    output logic        length,
    output logic        WR,
    output logic [15:0] writeData,
    output logic        NewCommand,
    input  logic [3:0]  state,
    input  logic [15:0] readData,
    output logic [15:0] rdata,
    output logic [2:0]  ack,
    output logic        err,
    output logic [1:0]  owner,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} fsm_t;

    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

    fsm_t        fsm, fsm_nxt;
    logic [9:0]  wdog;
    logic [1:0]  rr_last;
    logic        grant;
    logic [1:0]  gnt_id;
    logic        wdog_hit;
    logic        eng_done;
    logic        abort;
    logic [7:0]  sel_offset;
    logic        sel_len;
    logic        sel_wr;
    logic [15:0] sel_wdata;

    assign wdog_hit = (wdog == WDOG_LAST);
    assign eng_done = (state == ST_READ2) || (state == ST_WRITE2);
    // A completion seen on the same edge as the watchdog expiry wins.
    assign abort    = wdog_hit && ((fsm == ISSUE) || (fsm == BUSY && !eng_done));

    always_comb begin
        grant  = 1'b0;
        gnt_id = 2'd0;
        if (state == ST_WAIT) begin
            if (init_busy) begin
                grant  = req[0];
                gnt_id = 2'd0;
            end else if (req[1] && req[2]) begin
                grant  = 1'b1;
                gnt_id = (rr_last == 2'd1) ? 2'd2 : 2'd1;
            end else if (req[1]) begin
                grant  = 1'b1;
                gnt_id = 2'd1;
            end else if (req[2]) begin
                grant  = 1'b1;
                gnt_id = 2'd2;
            end
        end
    end

    always_comb begin
        sel_offset = '0;
        sel_len    = 1'b0;
        sel_wr     = 1'b0;
        sel_wdata  = '0;
        case (gnt_id)
            2'd0: begin
                sel_offset = req_offset[7:0];
                sel_len    = req_len[0];
                sel_wr     = req_wr[0];
                sel_wdata  = req_wdata[15:0];
            end
            2'd1: begin
                sel_offset = req_offset[15:8];
                sel_len    = req_len[1];
                sel_wr     = req_wr[1];
                sel_wdata  = req_wdata[31:16];
            end
            default: begin
                sel_offset = req_offset[23:16];
                sel_len    = req_len[2];
                sel_wr     = req_wr[2];
                sel_wdata  = req_wdata[47:32];
            end
        endcase
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:  if (grant) fsm_nxt = ISSUE;
            ISSUE: begin
                if (abort)                   fsm_nxt = DONE;
                else if (state == ST_ADDR0)  fsm_nxt = BUSY;
            end
            BUSY:  if (eng_done || abort) fsm_nxt = DONE;
            DONE:  fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            offset     <= '0;
            length     <= 1'b0;
            WR         <= 1'b0;
            writeData  <= '0;
            NewCommand <= 1'b0;
            rdata      <= '0;
            ack        <= '0;
            err        <= 1'b0;
            owner      <= 2'd0;
            busy       <= 1'b0;
            rr_last    <= 2'd2;
            wdog       <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (grant) begin
                        owner      <= gnt_id;
                        offset     <= sel_offset;
                        length     <= sel_len;
                        WR         <= sel_wr;
                        writeData  <= sel_wr ? sel_wdata : 16'h0000;
                        NewCommand <= 1'b1;
                        busy       <= 1'b1;
                        wdog       <= '0;
                    end
                end
                ISSUE, BUSY: begin
                    wdog <= wdog + 10'd1;
                    if (fsm == ISSUE && state == ST_ADDR0)
                        NewCommand <= 1'b0;
                    if (abort) begin
                        NewCommand <= 1'b0;
                        busy       <= 1'b0;
                        ack        <= 3'b001 << owner;
                        err        <= 1'b1;
                    end else if (fsm == BUSY && eng_done) begin
                        if (!WR) rdata <= readData;
                        busy <= 1'b0;
                        ack  <= 3'b001 << owner;
                    end
                end
                DONE: begin
                    if (owner != 2'd0) rr_last <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_io_arbiter.sv
// Bench for reg_io_arbiter: a small engine model, a vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_reg_io_arbiter;

    localparam logic [3:0] ST_WAIT   = 4'b1001;
    localparam logic [3:0] ST_ADDR0  = 4'b0000;
    localparam logic [3:0] ST_READ2  = 4'b0101;
    localparam logic [3:0] ST_WRITE2 = 4'b1000;
    localparam int         TIMEOUT   = 1023;

    logic        sysclk;
    logic        reset;
    logic        init_busy;
    logic [2:0]  req, req_wr, req_len;
    logic [23:0] req_offset;
    logic [47:0] req_wdata;
    logic [7:0]  offset;
    logic        length, WR, NewCommand, err, busy;
    logic [15:0] writeData, readData, rdata;
    logic [3:0]  state;
    logic [2:0]  ack;
    logic [1:0]  owner;

    reg_io_arbiter dut (
        .sysclk(sysclk), .reset(reset), .init_busy(init_busy),
        .req(req), .req_wr(req_wr), .req_len(req_len),
        .req_offset(req_offset), .req_wdata(req_wdata),
        .offset(offset), .length(length), .WR(WR), .writeData(writeData),
        .NewCommand(NewCommand), .state(state), .readData(readData),
        .rdata(rdata), .ack(ack), .err(err), .owner(owner), .busy(busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Engine model: WAIT -> Addr0 -> Addr1 -> 2 -> Read2/Write2 -> WAIT.
    logic [3:0]  eng_st;
    logic        eng_wr;
    logic        eng_stuck = 1'b0;
    logic        hold_en   = 1'b0;
    logic [3:0]  hold_val  = 4'b0011;
    logic [15:0] eng_data  = 16'h0000;

    always @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            eng_st <= ST_WAIT;
            eng_wr <= 1'b0;
        end else begin
            case (eng_st)
                ST_WAIT:  if (NewCommand) eng_st <= ST_ADDR0;
                ST_ADDR0: begin eng_wr <= WR; eng_st <= 4'b0001; end
                4'b0001:  if (!eng_stuck) eng_st <= 4'b0010;
                4'b0010:  eng_st <= eng_wr ? ST_WRITE2 : ST_READ2;
                default:  eng_st <= ST_WAIT;
            endcase
        end
    end

    assign state    = hold_en ? hold_val : eng_st;
    assign readData = eng_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge sysclk);
    endtask

    task automatic drive_cmd(input int who, input bit wr, input bit len,
                             input logic [7:0] ofs, input logic [15:0] wd);
        req_wr     = 3'($urandom);
        req_len    = 3'($urandom);
        req_offset = 24'($urandom);
        req_wdata  = {16'($urandom), 32'($urandom)};
        req_wr[who]            = wr;
        req_len[who]           = len;
        req_offset[8*who +: 8] = ofs;
        req_wdata[16*who +: 16] = wd;
        req = 3'b001 << who;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 3'b000;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    typedef struct {
        bit          ib;
        int          who;
        bit          wr;
        bit          len;
        logic [7:0]  ofs;
        logic [15:0] wd;
        logic [15:0] edata;
        logic [15:0] exp_wdata;
        logic [15:0] exp_rdata;
        logic [2:0]  exp_ack;
    } vec_t;

    task automatic exec(input vec_t v);
        logic [25:0] snap;
        bit addr0_seen, unstable, nc_bad, got, prev_fin, lat_ok;
        init_busy = v.ib;
        eng_data  = v.edata;
        drive_cmd(v.who, v.wr, v.len, v.ofs, v.wd);
        cyc();
        chk("grant_nc", NewCommand, 1);
        chk("grant_owner", owner, v.who);
        chk("grant_offset", offset, v.ofs);
        chk("grant_wr", WR, v.wr);
        chk("grant_wdata", writeData, v.exp_wdata);
        chk("grant_len", length, v.len);
        chk("grant_busy", busy, 1);
        snap = {offset, length, WR, writeData};
        addr0_seen = 0; unstable = 0; nc_bad = 0; got = 0; lat_ok = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            addr0_seen = addr0_seen | (state == ST_ADDR0);
            prev_fin   = (state == ST_READ2) || (state == ST_WRITE2);
            cyc();
            if (ack != 3'b000) begin
                got = 1;
                lat_ok = prev_fin;
            end else if (NewCommand !== !addr0_seen) begin
                nc_bad = 1;
            end
            if ({offset, length, WR, writeData} !== snap) unstable = 1;
        end
        chk("ack_seen", got, 1);
        chk("ack_value", ack, v.exp_ack);
        chk("ack_err", err, 0);
        chk("ack_rdata", rdata, v.exp_rdata);
        chk("ack_latency", lat_ok, 1);
        chk("nc_handshake", nc_bad, 0);
        chk("fields_stable", unstable, 0);
        chk("busy_at_ack", busy, 0);
        chk("nc_at_ack", NewCommand, 0);
        req = 3'b000;
        cyc();
        chk("ack_one_cycle", ack, 0);
        cyc();
    endtask

    function automatic int ack_id(input logic [2:0] a);
        case (a)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    vec_t vecs[6];
    vec_t vpost;

    // Randomized-run model state
    bit          pend[3];
    bit          c_wr[3], c_len[3];
    logic [7:0]  c_ofs[3];
    logic [15:0] c_wd[3];
    int          m_rr, exp_owner, ncmd, cnt, win, seq[4], nseq;
    bit          in_flight, exp_wr, nc_prev, m1, m2;
    logic [15:0] m_rdata;

    initial begin
        vecs[0] = '{1, 0, 0, 0, 8'hC0, 16'hFFFF, 16'h8872, 16'h0000, 16'h8872, 3'b001};
        vecs[1] = '{1, 0, 1, 1, 8'h12, 16'hA5A5, 16'h1111, 16'hA5A5, 16'h8872, 3'b001};
        vecs[2] = '{0, 2, 1, 0, 8'h70, 16'h01EE, 16'h2222, 16'h01EE, 16'h8872, 3'b100};
        vecs[3] = '{0, 1, 0, 1, 8'h34, 16'h9999, 16'hBEEF, 16'h0000, 16'hBEEF, 3'b010};
        vecs[4] = '{0, 2, 0, 0, 8'hFE, 16'h7777, 16'h0F0F, 16'h0000, 16'h0F0F, 3'b100};
        vecs[5] = '{0, 1, 1, 0, 8'h00, 16'hFFFF, 16'h3333, 16'hFFFF, 16'h0F0F, 3'b010};
        vpost   = '{0, 2, 0, 1, 8'h88, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 3'b100};

        reset = 1'b0; init_busy = 1'b1; req = 3'b000;
        req_wr = '0; req_len = '0; req_offset = '0; req_wdata = '0;
        cyc();
        chk("reset_outputs", {offset, length, WR, writeData, NewCommand, rdata, ack, err, owner, busy}, 0);
        reset = 1'b1;
        cyc();
        chk("post_reset_outputs", {offset, length, WR, writeData, NewCommand, rdata, ack, err, owner, busy}, 0);

        foreach (vecs[i]) exec(vecs[i]);

        // req[0] ignored once initialization is over
        init_busy = 1'b0;
        drive_cmd(0, 0, 0, 8'h11, 16'h0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cyc(); if (NewCommand) cnt++; end
        chk("req0_ignored", cnt, 0);
        req = 3'b000;
        cyc();

        // Hung engine: watchdog abort, then normal service
        eng_stuck = 1'b1;
        eng_data  = 16'hDEAD;
        drive_cmd(1, 0, 0, 8'h21, 16'h0);
        cyc();
        chk("stuck_grant", NewCommand, 1);
        cnt = 0;
        for (int i = 0; i < 1100 && ack == 3'b000; i++) begin cyc(); cnt++; end
        chk("wdog_cycles", cnt, TIMEOUT);
        chk("wdog_ack", ack, 3'b010);
        chk("wdog_err", err, 1);
        chk("wdog_nc", NewCommand, 0);
        chk("wdog_rdata", rdata, 16'h0F0F);
        req = 3'b000;
        eng_stuck = 1'b0;
        cyc();
        chk("wdog_err_pulse", err, 0);
        for (int i = 0; i < 6; i++) cyc();
        exec(vpost);

        // Engine away from ST_WAIT: no grant until it returns
        hold_en  = 1'b1;
        eng_data = 16'h4444;
        drive_cmd(1, 0, 0, 8'h44, 16'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin cyc(); if (NewCommand) cnt++; end
        chk("hold_no_grant", cnt, 0);
        hold_en = 1'b0;
        cyc();
        chk("hold_grant_nc", NewCommand, 1);
        chk("hold_grant_owner", owner, 1);
        for (int i = 0; i < 20 && ack == 3'b000; i++) cyc();
        chk("hold_ack", ack, 3'b010);
        chk("hold_rdata", rdata, 16'h4444);
        req = 3'b000;
        cyc(); cyc();

        // Reset while the engine is running the command
        eng_data = 16'h5555;
        drive_cmd(1, 0, 1, 8'h55, 16'h0);
        cyc(); cyc(); cyc();
        chk("in_busy_state", {busy, NewCommand}, 2'b10);
        reset = 1'b0;
        cyc();
        chk("mid_reset_outputs", {offset, length, WR, writeData, NewCommand, rdata, ack, err, owner, busy}, 0);
        reset = 1'b1;
        cyc();
        chk("reset_regrant_nc", NewCommand, 1);
        chk("reset_regrant_owner", owner, 1);
        for (int i = 0; i < 20 && ack == 3'b000; i++) cyc();
        chk("reset_regrant_ack", ack, 3'b010);
        chk("reset_regrant_rdata", rdata, 16'h5555);
        req = 3'b000;
        cyc();

        // Held off by init_busy, then strict alternation between 1 and 2
        do_reset();
        init_busy = 1'b1;
        req_wr = 3'b000;
        req = 3'b110;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cyc(); if (NewCommand) cnt++; end
        chk("init_blocks_1_2", cnt, 0);
        init_busy = 1'b0;
        req = 3'b111;
        nseq = 0;
        for (int i = 0; i < 100 && nseq < 4; i++) begin
            cyc();
            if (ack != 3'b000) begin seq[nseq] = ack_id(ack); nseq++; end
        end
        chk("alt_count", nseq, 4);
        chk("alt_0", seq[0], 1);
        chk("alt_1", seq[1], 2);
        chk("alt_2", seq[2], 1);
        chk("alt_3", seq[3], 2);
        req = 3'b000;
        for (int i = 0; i < 8; i++) cyc();

        // Randomized traffic from requesters 1 and 2 against a transaction model
        do_reset();
        init_busy = 1'b0;
        m_rr = 2; m_rdata = 16'h0000; in_flight = 0; nc_prev = 0;
        ncmd = 0; cnt = 0; exp_owner = 0; exp_wr = 0;
        pend[0] = 0; pend[1] = 0; pend[2] = 0;
        while (ncmd < 200 && cnt < 20000) begin
            cyc();
            cnt++;
            if (NewCommand && !nc_prev) begin
                m1 = req[1]; m2 = req[2];
                chk("rand_grant_legal", (m1 | m2) && !in_flight, 1);
                if (m1 && m2) win = (m_rr == 1) ? 2 : 1;
                else          win = m1 ? 1 : 2;
                chk("rand_owner", owner, win);
                chk("rand_offset", offset, c_ofs[win]);
                chk("rand_wr", WR, c_wr[win]);
                chk("rand_len", length, c_len[win]);
                chk("rand_wdata", writeData, c_wr[win] ? c_wd[win] : 16'h0000);
                in_flight = 1; exp_owner = win; exp_wr = c_wr[win];
                eng_data = 16'($urandom);
            end
            if (ack != 3'b000) begin
                chk("rand_ack_legal", in_flight, 1);
                chk("rand_ack", ack, 3'b001 << exp_owner);
                chk("rand_err", err, 0);
                if (!exp_wr) m_rdata = eng_data;
                chk("rand_rdata", rdata, m_rdata);
                m_rr = exp_owner;
                pend[exp_owner] = 0;
                in_flight = 0;
                ncmd++;
            end
            nc_prev = NewCommand;
            for (int r = 1; r <= 2; r++) begin
                if (!pend[r] && $urandom_range(0, 3) == 0) begin
                    pend[r]  = 1;
                    c_wr[r]  = 1'($urandom);
                    c_len[r] = 1'($urandom);
                    c_ofs[r] = 8'($urandom);
                    c_wd[r]  = 16'($urandom);
                end
            end
            req_wr = 3'($urandom); req_len = 3'($urandom);
            req_offset = 24'($urandom);
            req_wdata  = {16'($urandom), 32'($urandom)};
            for (int r = 1; r <= 2; r++) begin
                if (pend[r]) begin
                    req_wr[r] = c_wr[r];
                    req_len[r] = c_len[r];
                    req_offset[8*r +: 8] = c_ofs[r];
                    req_wdata[16*r +: 16] = c_wd[r];
                end
            end
            req = {pend[2], pend[1], 1'($urandom)};
        end
        chk("rand_cmds_done", ncmd >= 200, 1);
        req = 3'b000;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
